// File: rtl/alu_stream_arbiter.sv
// alu_stream_arbiter: shares one combinational 8-bit ALU between two
// operand-stream requesters. Whole bursts are granted round-robin, results
// leave as a valid/last framed stream, and an idle gap follows every burst.
module alu_stream_arbiter #(
    parameter int MAX_BURST  = 16,
    parameter int GAP_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_A,
    input  logic [7:0] req0_B,
    input  logic [3:0] req0_instr,
    input  logic       req0_last,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_A,
    input  logic [7:0] req1_B,
    input  logic [3:0] req1_instr,
    input  logic       req1_last,
    output logic [7:0] alu_A,
    output logic [7:0] alu_B,
    output logic [3:0] alu_instruction,
    input  logic [7:0] alu_F,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_src,
    output logic       busy,
    output logic       burst_trunc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 2) + 1;
    // Count value seen while the MAX_BURST-th beat is being accepted.
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    // DRAIN lasts two pipeline-flush cycles plus the configured gap.
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_CYCLES + 1);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             ready0_q, ready0_d;
    logic             ready1_q, ready1_d;
    logic             busy_q, busy_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_i_q, alu_i_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q, s1_last_d;
    logic             s1_src_q, s1_src_d;
    logic             s1_trunc_q, s1_trunc_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_src_q, out_src_d;
    logic             trunc_q, trunc_d;

    // Operands of the current owner; the non-owner is ignored entirely.
    logic       sel_valid_s;
    logic       sel_last_s;
    logic [7:0] sel_a_s;
    logic [7:0] sel_b_s;
    logic [3:0] sel_i_s;
    logic       accept_s;
    logic       force_s;
    logic       end_s;

    assign sel_valid_s = owner_q ? req1_valid : req0_valid;
    assign sel_last_s  = owner_q ? req1_last  : req0_last;
    assign sel_a_s     = owner_q ? req1_A     : req0_A;
    assign sel_b_s     = owner_q ? req1_B     : req0_B;
    assign sel_i_s     = owner_q ? req1_instr : req0_instr;
    assign accept_s    = (state_q == BURST) && sel_valid_s;
    assign force_s     = accept_s && !sel_last_s && (beat_cnt_q == LAST_BEAT);
    assign end_s       = sel_last_s || force_s;

    // Burst arbitration FSM: grant selection, beat counting, post-burst gap.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    owner_d = rr_q;
                    state_d = BURST;
                end else if (req0_valid) begin
                    owner_d = 1'b0;
                    state_d = BURST;
                end else if (req1_valid) begin
                    owner_d = 1'b1;
                    state_d = BURST;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (accept_s) begin
                    if (end_s) begin
                        state_d    = DRAIN;
                        rr_d       = ~owner_q;
                        beat_cnt_d = '0;
                        gap_cnt_d  = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = BURST;
                end
            end
            DRAIN: begin
                if (gap_cnt_q == GAP_END) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready0_d = (state_d == BURST) && (owner_d == 1'b0);
        ready1_d = (state_d == BURST) && (owner_d == 1'b1);
        busy_d   = (state_d != IDLE);
    end

    // Two-stage result pipeline: operand capture, then ALU result capture.
    always_comb begin
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_i_d    = alu_i_q;
        s1_src_d   = s1_src_q;
        s1_valid_d = 1'b0;
        s1_last_d  = 1'b0;
        s1_trunc_d = 1'b0;
        if (accept_s) begin
            alu_a_d    = sel_a_s;
            alu_b_d    = sel_b_s;
            alu_i_d    = sel_i_s;
            s1_valid_d = 1'b1;
            s1_last_d  = end_s;
            s1_trunc_d = force_s;
            s1_src_d   = owner_q;
        end else begin
            s1_valid_d = 1'b0;
        end
        out_valid_d = s1_valid_q;
        out_last_d  = s1_valid_q && s1_last_q;
        trunc_d     = s1_valid_q && s1_trunc_q;
        if (s1_valid_q) begin
            out_data_d = alu_F;
            out_src_d  = s1_src_q;
        end else begin
            out_data_d = out_data_q;
            out_src_d  = out_src_q;
        end
    end

    // State and pipeline registers; reset discards any in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            beat_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
            busy_q      <= 1'b0;
            alu_a_q     <= 8'd0;
            alu_b_q     <= 8'd0;
            alu_i_q     <= 4'd0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_src_q    <= 1'b0;
            s1_trunc_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            beat_cnt_q  <= beat_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            ready0_q    <= ready0_d;
            ready1_q    <= ready1_d;
            busy_q      <= busy_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_i_q     <= alu_i_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_src_q    <= s1_src_d;
            s1_trunc_q  <= s1_trunc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            trunc_q     <= trunc_d;
        end
    end

    assign req0_ready      = ready0_q;
    assign req1_ready      = ready1_q;
    assign busy            = busy_q;
    assign alu_A           = alu_a_q;
    assign alu_B           = alu_b_q;
    assign alu_instruction = alu_i_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_last        = out_last_q;
    assign out_src         = out_src_q;
    assign burst_trunc     = trunc_q;

endmodule

// File: tb/tb_alu_stream_arbiter.sv
// Bench for alu_stream_arbiter: directed bursts, a cycle-numbered
// transaction model of arbitration/latency, and literal spot checks.
module tb_alu_stream_arbiter;

    localparam int MAXB = 16;
    localparam int GAP  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_last;
    logic [7:0] req0_A, req0_B;
    logic [3:0] req0_instr;
    logic       req1_valid, req1_ready, req1_last;
    logic [7:0] req1_A, req1_B;
    logic [3:0] req1_instr;
    logic [7:0] alu_A, alu_B, alu_F;
    logic [3:0] alu_instruction;
    logic       out_valid, out_last, out_src, busy, burst_trunc;
    logic [7:0] out_data;

    alu_stream_arbiter #(.MAX_BURST(MAXB), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A),
        .req0_B(req0_B), .req0_instr(req0_instr), .req0_last(req0_last),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A),
        .req1_B(req1_B), .req1_instr(req1_instr), .req1_last(req1_last),
        .alu_A(alu_A), .alu_B(alu_B), .alu_instruction(alu_instruction),
        .alu_F(alu_F), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_src(out_src), .busy(busy),
        .burst_trunc(burst_trunc)
    );

    // Bench ALU: F = A + B
    assign alu_F = alu_A + alu_B;

    always #5 clk = ~clk;

    typedef struct packed {
        logic       bubble;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] i;
        logic       last;
    } beat_t;

    typedef struct packed {
        int         due;
        logic [7:0] d;
        logic       last;
        logic       src;
        logic       trunc;
    } exp_t;

    typedef struct packed {
        int         cyc;
        logic [7:0] d;
        logic       last;
        logic       src;
        logic       trunc;
    } obs_t;

    typedef struct packed {
        int   cyc;
        logic src;
    } acc_t;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  exp_q[$];
    obs_t  log_q[$];
    acc_t  acc_q[$];

    int checks   = 0;
    int failures = 0;

    // model state, all in plain cycle numbers
    int   m_cyc   = 0;
    int   m_owner = -1;
    int   m_grant = 0;
    int   m_free  = 0;
    int   m_rr    = 0;
    int   m_beats = 0;
    logic [7:0] m_a = 8'd0;
    logic [7:0] m_b = 8'd0;
    logic [3:0] m_i = 4'd0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int a, input int b, input int i, input bit l);
        beat_t t;
        t.bubble = 1'b0;
        t.a = 8'(a);
        t.b = 8'(b);
        t.i = 4'(i);
        t.last = l;
        return t;
    endfunction

    function automatic beat_t bub();
        beat_t t;
        t = '0;
        t.bubble = 1'b1;
        return t;
    endfunction

    // Requester drivers: present queue heads, pop on handshake or bubble.
    initial begin
        logic f0, f1;
        req0_valid = 1'b0; req0_A = 8'd0; req0_B = 8'd0; req0_instr = 4'd0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_A = 8'd0; req1_B = 8'd0; req1_instr = 4'd0; req1_last = 1'b0;
        forever begin
            @(negedge clk);
            f0 = req0_valid && req0_ready;
            f1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (q0.size() > 0 && (f0 || q0[0].bubble)) void'(q0.pop_front());
            if (q1.size() > 0 && (f1 || q1[0].bubble)) void'(q1.pop_front());
            if (q0.size() > 0 && !q0[0].bubble) begin
                req0_valid = 1'b1; req0_A = q0[0].a; req0_B = q0[0].b;
                req0_instr = q0[0].i; req0_last = q0[0].last;
            end else begin
                req0_valid = 1'b0;
            end
            if (q1.size() > 0 && !q1[0].bubble) begin
                req1_valid = 1'b1; req1_A = q1[0].a; req1_B = q1[0].b;
                req1_instr = q1[0].i; req1_last = q1[0].last;
            end else begin
                req1_valid = 1'b0;
            end
        end
    end

    // Model + compare: every cycle, check DUT outputs, then advance model.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_owner = -1; m_free = 0; m_rr = 0; m_beats = 0;
            m_a = 8'd0; m_b = 8'd0; m_i = 4'd0;
            exp_q.delete();
            chk("rst out_valid", int'(out_valid), 0);
            chk("rst busy", int'(busy), 0);
            chk("rst ready", int'({req0_ready, req1_ready}), 0);
            chk("rst out_last", int'(out_last), 0);
            chk("rst alu_A", int'(alu_A), 0);
        end else begin
            bit   idle_now;
            exp_t e;
            idle_now = (m_owner == -1) && (m_cyc >= m_free);
            chk("req0_ready", int'(req0_ready), int'(m_owner == 0 && m_cyc >= m_grant));
            chk("req1_ready", int'(req1_ready), int'(m_owner == 1 && m_cyc >= m_grant));
            chk("busy", int'(busy), int'(!idle_now));
            if (out_valid) log_q.push_back('{m_cyc, out_data, out_last, out_src, burst_trunc});
            if (exp_q.size() > 0 && exp_q[0].due == m_cyc) begin
                e = exp_q.pop_front();
                chk("out_valid", int'(out_valid), 1);
                chk("out_data", int'(out_data), int'(e.d));
                chk("out_last", int'(out_last), int'(e.last));
                chk("out_src", int'(out_src), int'(e.src));
                chk("burst_trunc", int'(burst_trunc), int'(e.trunc));
            end else begin
                chk("out_valid idle", int'(out_valid), 0);
                chk("out_last idle", int'(out_last), 0);
                chk("burst_trunc idle", int'(burst_trunc), 0);
            end
            chk("alu_A", int'(alu_A), int'(m_a));
            chk("alu_B", int'(alu_B), int'(m_b));
            chk("alu_instruction", int'(alu_instruction), int'(m_i));
            if (m_owner >= 0 && m_cyc >= m_grant) begin
                logic       v, l, tr;
                logic [7:0] a, b;
                logic [3:0] ins;
                v   = (m_owner == 1) ? req1_valid : req0_valid;
                l   = (m_owner == 1) ? req1_last  : req0_last;
                a   = (m_owner == 1) ? req1_A     : req0_A;
                b   = (m_owner == 1) ? req1_B     : req0_B;
                ins = (m_owner == 1) ? req1_instr : req0_instr;
                if (v) begin
                    m_beats++;
                    tr = !l && (m_beats == MAXB);
                    exp_q.push_back('{m_cyc + 2, 8'(a + b), l || tr, m_owner[0], tr});
                    acc_q.push_back('{m_cyc, m_owner[0]});
                    m_a = a; m_b = b; m_i = ins;
                    if (l || tr) begin
                        m_rr    = 1 - m_owner;
                        m_owner = -1;
                        m_beats = 0;
                        m_free  = m_cyc + GAP + 3;
                    end
                end
            end else if (idle_now) begin
                if (req0_valid && req1_valid) m_owner = m_rr;
                else if (req0_valid) m_owner = 0;
                else if (req1_valid) m_owner = 1;
                if (m_owner >= 0) m_grant = m_cyc + 1;
            end
        end
        m_cyc++;
    end

    task automatic wait_quiet(input string nm);
        int n;
        n = 0;
        while (n < 400 && !(q0.size() == 0 && q1.size() == 0 && m_owner == -1 &&
                            exp_q.size() == 0 && m_cyc >= m_free)) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " completes"}, int'(n < 400), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s, a0, tcount, n;
        rst_n = 1'b0;
        // --- both requesters valid at reset release: req0 first (rr=0)
        q0.push_back(mk(10, 1, 1, 0)); q0.push_back(mk(20, 2, 2, 1));
        q1.push_back(mk(30, 3, 3, 0)); q1.push_back(mk(40, 4, 4, 1));
        s = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_quiet("reset-release contention");
        chk("A beats", log_q.size() - s, 4);
        if (log_q.size() - s >= 4) begin
            chk("A d0", int'(log_q[s].d), 11);
            chk("A src0", int'(log_q[s].src), 0);
            chk("A last1", int'(log_q[s+1].last), 1);
            chk("A d2", int'(log_q[s+2].d), 33);
            chk("A src2", int'(log_q[s+2].src), 1);
            chk("A spacing>=GAP+3", int'(log_q[s+2].cyc - log_q[s+1].cyc >= GAP + 3), 1);
        end

        // --- req0 3 beats: 3,7,11 back to back, last on 11
        @(negedge clk);
        s = log_q.size(); a0 = acc_q.size();
        q0.push_back(mk(1, 2, 5, 0)); q0.push_back(mk(3, 4, 6, 0)); q0.push_back(mk(5, 6, 7, 1));
        wait_quiet("three-beat burst");
        chk("B beats", log_q.size() - s, 3);
        if (log_q.size() - s >= 3 && acc_q.size() - a0 >= 1) begin
            chk("B d0", int'(log_q[s].d), 3);
            chk("B d1", int'(log_q[s+1].d), 7);
            chk("B d2", int'(log_q[s+2].d), 11);
            chk("B consecutive", log_q[s+2].cyc - log_q[s].cyc, 2);
            chk("B latency", log_q[s].cyc - acc_q[a0].cyc, 2);
            chk("B last on 11", int'({log_q[s].last, log_q[s+1].last, log_q[s+2].last}), 1);
            chk("B src", int'(log_q[s+2].src), 0);
        end

        // --- contention after req0 owned last: req1 wins, then req0
        @(negedge clk);
        s = log_q.size();
        q0.push_back(mk(7, 7, 8, 1)); q1.push_back(mk(9, 9, 9, 1));
        wait_quiet("rr contention");
        if (log_q.size() - s >= 2) begin
            chk("C first src", int'(log_q[s].src), 1);
            chk("C second src", int'(log_q[s+1].src), 0);
        end else chk("C beats", log_q.size() - s, 2);

        // --- truncation: req1 20 beats without last, then a closing beat
        @(negedge clk);
        s = log_q.size();
        for (int i = 1; i <= 20; i++) q1.push_back(mk(i, 2 * i, i, 0));
        q1.push_back(mk(50, 50, 0, 1));
        wait_quiet("truncation");
        chk("E beats", log_q.size() - s, 21);
        if (log_q.size() - s >= 21) begin
            tcount = 0;
            for (int i = s; i < s + 21; i++) tcount += int'(log_q[i].trunc);
            chk("E trunc count", tcount, 1);
            chk("E beat16 last", int'(log_q[s+15].last), 1);
            chk("E beat16 trunc", int'(log_q[s+15].trunc), 1);
            chk("E beat16 data", int'(log_q[s+15].d), 48);
            chk("E beat15 last", int'(log_q[s+14].last), 0);
            chk("E resume gap", int'(log_q[s+16].cyc - log_q[s+15].cyc >= GAP + 3), 1);
            chk("E beat17 data", int'(log_q[s+16].d), 51);
            chk("E final data", int'(log_q[s+20].d), 100);
        end

        // --- req0 pauses mid-burst while req1 holds valid
        @(negedge clk);
        s = log_q.size();
        q0.push_back(mk(1, 1, 1, 0)); q0.push_back(mk(2, 2, 2, 0));
        for (int i = 0; i < 4; i++) q0.push_back(bub());
        q0.push_back(mk(3, 3, 3, 0)); q0.push_back(mk(4, 4, 4, 1));
        q1.push_back(mk(100, 1, 15, 1));
        wait_quiet("gap burst");
        chk("F beats", log_q.size() - s, 5);
        if (log_q.size() - s >= 5) begin
            n = 0;
            for (int i = s; i < s + 4; i++) n += int'(log_q[i].src);
            chk("F no interleave", n, 0);
            chk("F req0 tail", int'(log_q[s+3].d), 8);
            chk("F req1 after", int'(log_q[s+4].src), 1);
            chk("F req1 data", int'(log_q[s+4].d), 101);
        end

        // --- single requester, two one-beat bursts with valid held high
        @(negedge clk);
        a0 = acc_q.size();
        q0.push_back(mk(11, 0, 0, 1)); q0.push_back(mk(12, 0, 0, 1));
        wait_quiet("back-to-back");
        if (acc_q.size() - a0 >= 2) chk("G accept spacing", acc_q[a0+1].cyc - acc_q[a0].cyc, GAP + 4);
        else chk("G accepts", acc_q.size() - a0, 2);

        // --- async reset with a beat in stage 1
        @(negedge clk);
        s = log_q.size(); a0 = acc_q.size();
        q0.push_back(mk(60, 1, 0, 0)); q0.push_back(mk(70, 1, 0, 0)); q0.push_back(mk(80, 1, 0, 1));
        n = 0;
        while (acc_q.size() - a0 < 2 && n < 50) begin @(negedge clk); n++; end
        chk("H reached stage1", int'(n < 50), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("H async out_valid", int'(out_valid), 0);
        chk("H async busy", int'(busy), 0);
        chk("H async out_last", int'(out_last), 0);
        q0.delete(); q1.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n = 0;
        for (int i = s; i < log_q.size(); i++) n += int'(log_q[i].last);
        chk("H no out_last", n, 0);
        // rr back to 0: req0 wins contention although it owned last
        s = log_q.size();
        q0.push_back(mk(5, 5, 0, 1)); q1.push_back(mk(6, 6, 0, 1));
        wait_quiet("post-reset contention");
        if (log_q.size() - s >= 2) begin
            chk("H first src", int'(log_q[s].src), 0);
            chk("H second src", int'(log_q[s+1].src), 1);
        end else chk("H beats", log_q.size() - s, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
